// File: rtl/gcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_pkg                                                                    |
// | Shared definitions for the gcd / modular-inverse datapaths: FSM state      |
// | encoding, default operand width and the iteration bound helper.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ITER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_W    = 40;
  localparam int ITER_MAX = 4 * DEF_W;

  // Worst-case number of ITER cycles for a given operand width.
  function automatic int iter_max(input int w);
    return 4 * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_inv_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_inv_step                                                               |
// | One combinational step of the binary extended Euclidean algorithm.         |
// | Halves an even u (or v) together with its coefficient, otherwise subtracts |
// | the smaller from the larger and updates the coefficient modulo m.          |
// | Ports: u_i, v_i, x1_i, x2_i, m_i  -> current state and modulus             |
// |        u_o, v_o, x1_o, x2_o       -> next state                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mod_inv_step
  import gcd_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] v_i,
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] u_o,
  output logic [W-1:0] v_o,
  output logic [W-1:0] x1_o,
  output logic [W-1:0] x2_o
);

  // x/2 mod m for odd m: an odd x is made even by adding m first.
  // The sum is kept in W+1 bits so the carry survives the shift.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x,
                                            input logic [W-1:0] md);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
    return s[W:1];
  endfunction

  // (x - y) mod m with x, y already in [0, m-1]; the sign bit of the
  // W+1-bit difference selects the wrap-around correction.
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [W-1:0] md);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) begin
      d = d + {1'b0, md};
    end
    return d[W-1:0];
  endfunction

  always_comb begin
    u_o  = u_i;
    v_o  = v_i;
    x1_o = x1_i;
    x2_o = x2_i;
    if (!u_i[0]) begin
      u_o  = u_i >> 1;
      x1_o = half_mod(x1_i, m_i);
    end else if (!v_i[0]) begin
      v_o  = v_i >> 1;
      x2_o = half_mod(x2_i, m_i);
    end else if (u_i >= v_i) begin
      u_o  = u_i - v_i;
      x1_o = sub_mod(x1_i, x2_i, m_i);
    end else begin
      v_o  = v_i - u_i;
      x2_o = sub_mod(x2_i, x1_i, m_i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_inverse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_inverse                                                                |
// | Modular inverse r = a^-1 mod m (m odd, >= 3) via binary extended Euclid.   |
// | Operands enter on a valid/ready handshake; the result is held until taken. |
// | Ports: clk, reset (async, active-high)                                     |
// |        in_valid/in_ready, a, m      -> operand handshake                   |
// |        out_valid/out_ready, result, err -> result handshake                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mod_inverse
  import gcd_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         err
);

  localparam logic [W-1:0]     ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     THREE    = {{(W-2){1'b0}}, 2'b11};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(iter_max(W) - 1);

  state_t           state_q;
  logic [W-1:0]     a_q, m_q;
  logic [W-1:0]     u_q, v_q, x1_q, x2_q;
  logic [W-1:0]     u_d, v_d, x1_d, x2_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, out_valid_q, err_q;
  logic [W-1:0]     result_q;

  mod_inv_step #(.W(W)) u_step (
    .u_i  (u_q),
    .v_i  (v_q),
    .x1_i (x1_q),
    .x2_i (x2_q),
    .m_i  (m_q),
    .u_o  (u_d),
    .v_o  (v_d),
    .x1_o (x1_d),
    .x2_o (x2_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      m_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            m_q        <= m;
            in_ready_q <= 1'b0;
            state_q    <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          cnt_q <= '0;
          if (!m_q[0] || (m_q < THREE) || (a_q == '0) || (a_q >= m_q)) begin
            result_q    <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            u_q     <= a_q;
            v_q     <= m_q;
            x1_q    <= ONE;
            x2_q    <= '0;
            state_q <= ST_ITER;
          end
        end

        ST_ITER: begin
          if (u_q == ONE) begin
            result_q    <= x1_q;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (v_q == ONE) begin
            result_q    <= x2_q;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if ((u_q == '0) || (cnt_q == CNT_LAST)) begin
            // u reaching 0 means gcd(a,m) > 1; the counter limit is a
            // safety net that legal operands never hit.
            result_q    <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            u_q   <= u_d;
            v_q   <= v_d;
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_inverse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mod_inverse                                                             |
// | Self-checking bench: directed vector table, latency, backpressure and      |
// | mid-operation reset sequences, plus randomized pairs checked by identity.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mod_inverse;

  localparam int W = 40;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         err;

  int n_cmp;
  int n_bad;

  mod_inverse #(.W(W), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (in_a),
    .m         (in_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [W-1:0] exp_r;
    logic         exp_e;
    int           exp_lat;   // edges from accept to out_valid; 0 = only bound-checked
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] gcd64(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Runs one full transaction with out_ready held high. lat counts rising
  // edges from the accepting edge (inclusive) to the one raising out_valid.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tm,
                       output logic [W-1:0] r, output logic e, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    in_a      = ta;
    in_m      = tm;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '1;   // operands must already be captured
    in_m     = '1;
    lat      = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_valid_timeout: got 0, expected 1 (a=%0d m=%0d)", ta, tm);
    end
    r = result;
    e = err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         e;
    int           lat;
    logic [W-1:0] ta, tm;
    logic [63:0]  rnd;
    logic [79:0]  prod;

    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{40'd3,             40'd7,             40'd5,             1'b0, 0};
    vecs[1]  = '{40'd2,             40'd1099511627775, 40'd549755813888,  1'b0, 4};
    vecs[2]  = '{40'd12,            40'd15,            40'd0,             1'b1, 0};
    vecs[3]  = '{40'd5,             40'd16,            40'd0,             1'b1, 2};
    vecs[4]  = '{40'd0,             40'd7,             40'd0,             1'b1, 2};
    vecs[5]  = '{40'd7,             40'd7,             40'd0,             1'b1, 2};
    vecs[6]  = '{40'd1,             40'd13,            40'd1,             1'b0, 3};
    vecs[7]  = '{40'd4,             40'd9,             40'd7,             1'b0, 0};
    vecs[8]  = '{40'd2,             40'd1,             40'd0,             1'b1, 2};
    vecs[9]  = '{40'd3,             40'd11,            40'd4,             1'b0, 0};
    vecs[10] = '{40'd10,            40'd21,            40'd19,            1'b0, 0};
    vecs[11] = '{40'd6,             40'd9,             40'd0,             1'b1, 0};
    vecs[12] = '{40'd1099511627774, 40'd1099511627775, 40'd1099511627774, 1'b0, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_m      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result",    64'(result),    64'd0);
    chk("reset_err",       64'(err),       64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].m, r, e, lat);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].exp_r));
      chk($sformatf("vec%0d_err", i),    64'(e), 64'(vecs[i].exp_e));
      if (vecs[i].exp_lat != 0)
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_iter_le_160", i), 64'(lat - 2 <= 160), 64'd1);
      chk($sformatf("vec%0d_in_ready_after", i), 64'(in_ready), 64'd1);
    end

    // Backpressure: result held, no new accept while DONE
    @(negedge clk);
    in_a      = 40'd3;
    in_m      = 40'd7;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_a = 40'd4;
    in_m = 40'd9;   // keep in_valid high with new operands
    lat  = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_out_valid_rise", 64'(out_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_result", k),    64'(result),    64'd5);
      chk($sformatf("bp%0d_err", k),       64'(err),       64'd0);
      chk($sformatf("bp%0d_in_ready", k),  64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready",  64'(in_ready),  64'd1);

    // Reset while iterating aborts the operation
    @(negedge clk);
    in_a     = 40'd5;
    in_m     = 40'd1000003;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy_in_ready",  64'(in_ready),  64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    do_op(40'd4, 40'd9, r, e, lat);
    chk("after_abort_result", 64'(r), 64'd7);
    chk("after_abort_err",    64'(e), 64'd0);

    // Random pairs, checked by the inverse identity / gcd
    for (int i = 0; i < 250; i++) begin
      rnd = {$urandom(), $urandom()};
      if (i % 2 == 0) tm = W'($urandom_range(3, 999)) | 40'd1;
      else            tm = rnd[W-1:0] | 40'd1;
      if (tm < 40'd3) tm = 40'd3;
      rnd = {$urandom(), $urandom()};
      ta  = W'(rnd % 64'(tm));
      do_op(ta, tm, r, e, lat);
      if (gcd64(64'(ta), 64'(tm)) == 64'd1) begin
        prod = 80'(r) * 80'(ta);
        chk($sformatf("rnd%0d_err", i), 64'(e), 64'd0);
        chk($sformatf("rnd%0d_inverse", i), 64'(prod % 80'(tm)), 64'd1);
      end else begin
        chk($sformatf("rnd%0d_err", i),    64'(e), 64'd1);
        chk($sformatf("rnd%0d_result", i), 64'(r), 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
